// File: rtl/mp_add_seq_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Limb width, FSM state encoding and a limb extraction helper.
package mp_add_pkg;

    localparam int LIMB_W      = 16;
    localparam int ADD_LAT_DEF = 2;
    localparam int MAX_W       = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    // Operands are zero-extended to MAX_W by the caller so one helper serves any WORDS.
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [MAX_W-1:0] v,
                                                   input int unsigned       k);
        logic [MAX_W-1:0] t;
        t = v >> (LIMB_W * k);
        return t[LIMB_W-1:0];
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle for mp_add_seq; op_sub exists only when
// MPADD_SUB_EN is defined.
interface mp_add_seq_if
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
);
    localparam int W = LIMB_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MPADD_SUB_EN
    logic         op_sub;

    modport master (output in_valid, a, b, cin, op_sub, res_ready,
                    input  in_ready, res_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, op_sub, res_ready,
                    output in_ready, res_valid, sum, cout);
`else
    modport master (output in_valid, a, b, cin, res_ready,
                    input  in_ready, res_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, res_ready,
                    output in_ready, res_valid, sum, cout);
`endif

endinterface

// File: rtl/mp_add_seq_add16_reg.sv
// 16-bit adder slice with registered inputs and registered outputs (2-cycle latency).
// No reset: the sequencer decides when the outputs are meaningful.
module add16_reg (
    input  logic        clk,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        ci_i,
    output logic [15:0] s_o,
    output logic        co_o
);
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        ci_q;
    logic [15:0] s_q;
    logic        co_q;

    always_ff @(posedge clk) begin
        a_q          <= a_i;
        b_q          <= b_i;
        ci_q         <= ci_i;
        {co_q, s_q}  <= 17'(a_q) + 17'(b_q) + 17'(ci_q);
    end

    assign s_o  = s_q;
    assign co_o = co_q;

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: WORDS limbs through one shared add16_reg, LS limb first.
// Optional subtract mode under MPADD_SUB_EN (op_sub inverts B and forces carry-in to 1).
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mp_add_seq_if.slave bus
);
    localparam int W  = LIMB_W * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(ADD_LAT + 1);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic [LIMB_W-1:0] sl_a, sl_b, sl_s;
    logic              sl_ci, sl_co;
    logic              cap_en;
    logic [KW-1:0]     cap_idx;
    logic              in_ready, res_valid;
    logic [W-1:0]      b_acc;
    logic              cin_acc;

    always_comb begin
`ifdef MPADD_SUB_EN
        b_acc   = bus.op_sub ? ~bus.b : bus.b;
        cin_acc = bus.op_sub ? 1'b1 : bus.cin;
`else
        b_acc   = bus.b;
        cin_acc = bus.cin;
`endif
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        sl_a      = '0;
        sl_b      = '0;
        sl_ci     = 1'b0;
        cap_en    = 1'b0;
        cap_idx   = k_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = b_acc;
                    cin_d   = cin_acc;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sl_a    = limb_sel(MAX_W'(a_q), 32'(k_q));
                sl_b    = limb_sel(MAX_W'(b_q), 32'(k_q));
                // The previous limb's result is visible now: chain its carry and store it.
                sl_ci   = (k_q == '0) ? cin_q : sl_co;
                cap_en  = (k_q != '0);
                cap_idx = k_q - KW'(1);
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(ADD_LAT - 1)) begin
                    cap_en  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(ADD_LAT - 2) && k_q != KW'(WORDS - 1)) begin
                    k_d     = k_q + KW'(1);
                    state_d = ISSUE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_en) begin
            sum_d[LIMB_W*cap_idx +: LIMB_W] = sl_s;
            cout_d                          = sl_co;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    add16_reg u_slice (
        .clk  (clk),
        .a_i  (sl_a),
        .b_i  (sl_b),
        .ci_i (sl_ci),
        .s_o  (sl_s),
        .co_o (sl_co)
    );

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_mp_add_seq;
    import mp_add_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam int LAT   = WORDS * 2 + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sub_sel = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mp_add_seq_if #(.WORDS(WORDS)) bus ();

    mp_add_seq #(.WORDS(WORDS), .ADD_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
`ifdef MPADD_SUB_EN
        bus.op_sub   = sub_sel;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = rnd64();
        bus.b        = rnd64();
        bus.cin      = $urandom_range(0, 1);
`ifdef MPADD_SUB_EN
        bus.op_sub   = $urandom_range(0, 1);
`endif
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co, output int lat);
        accept_op(a, b, cin);
        wait_result(lat);
        s  = bus.sum;
        co = bus.cout;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [W-1:0] exp_s, input logic exp_c);
        logic [W-1:0] s;
        logic         co;
        int           lat;
        run_op(a, b, cin, s, co, lat);
        checks++; if (s !== exp_s) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, s, exp_s); end
        checks++; if (co !== exp_c) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, co, exp_c); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a = rnd64();
        logic [W-1:0] b = rnd64();
        logic [W:0]   exp = model(a, b, 1'b1, sub_sel);
        logic [W-1:0] s;
        logic         co;
        int           lat;
        accept_op(a, b, 1'b1);
        wait_result(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.sum !== exp[W-1:0] || bus.cout !== exp[W] || bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got sum=%h cout=%b vld=%b rdy=%b expected sum=%h cout=%b vld=1 rdy=0",
                         i, bus.sum, bus.cout, bus.res_valid, bus.in_ready, exp[W-1:0], exp[W]);
            end
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", bus.res_valid, bus.in_ready);
        end
        a   = rnd64();
        b   = rnd64();
        exp = model(a, b, 1'b0, sub_sel);
        run_op(a, b, 1'b0, s, co, lat);
        checks++;
        if (s !== exp[W-1:0] || co !== exp[W] || lat !== LAT) begin
            errors++;
            $display("FAIL bp_next_op: got sum=%h cout=%b lat=%0d expected sum=%h cout=%b lat=%0d",
                     s, co, lat, exp[W-1:0], exp[W], LAT);
        end
    endtask

    task automatic test_early_ready();
        logic [W-1:0] a = rnd64();
        logic [W-1:0] b = rnd64();
        logic [W:0]   exp = model(a, b, 1'b0, sub_sel);
        int           lat;
        bus.res_ready = 1'b1;
        accept_op(a, b, 1'b0);
        wait_result(lat);
        checks++;
        if (lat !== LAT || bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin
            errors++;
            $display("FAIL early_ready: got lat=%0d sum=%h cout=%b expected lat=%0d sum=%h cout=%b",
                     lat, bus.sum, bus.cout, LAT, exp[W-1:0], exp[W]);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL early_ready_drop: got %b expected 0", bus.res_valid); end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        accept_op(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got vld=%b rdy=%b sum=%h cout=%b expected vld=0 rdy=1 sum=0 cout=0",
                     bus.res_valid, bus.in_ready, bus.sum, bus.cout);
        end
        rst_n = 1'b1;
        run_op(64'd1, 64'd1, 1'b0, s, co, lat);
        checks++;
        if (s !== 64'd2 || co !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL midrst_next: got sum=%h cout=%b lat=%0d expected sum=2 cout=0 lat=%0d", s, co, lat, LAT);
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] a, b, s;
        logic         cin, co;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < n; i++) begin
            a   = (i % 7 == 3) ? '1 : rnd64();
            b   = (i % 5 == 2) ? '1 : rnd64();
            cin = $urandom_range(0, 1);
            exp = model(a, b, cin, sub_sel);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(a, b, cin, s, co, lat);
            checks++;
            if (s !== exp[W-1:0] || co !== exp[W] || lat !== LAT) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b lat=%0d expected sum=%h cout=%b lat=%0d",
                         i, a, b, cin, sub_sel, s, co, lat, exp[W-1:0], exp[W], LAT);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.res_ready = 1'b0;
`ifdef MPADD_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        test_reset();
        test_directed("carry_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
        test_directed("plain_add", 64'h0001_0002_0003_0004, 64'h1000_2000_3000_4000, 1'b0,
                      64'h1001_2002_3003_4004, 1'b0);
        test_directed("limb_boundary", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0,
                      64'h0000_0000_0001_0000, 1'b0);
        test_directed("top_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1,
                      64'h0000_0000_0000_0002, 1'b1);
        test_backpressure();
        test_early_ready();
        test_reset_mid_op();
        test_random(25);
`ifdef MPADD_SUB_EN
        sub_sel = 1'b1;
        test_directed("sub_neg", 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        test_directed("sub_pos", 64'd7, 64'd5, 1'b0, 64'd2, 1'b1);
        test_random(15);
        sub_sel = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
